// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the instruction-memory responder.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Word returned in place of an instruction when a fetch faults.
  localparam logic [WORD_W-1:0] INSTR_FAULT_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch/response handshake plus program-store load port.
interface instr_mem_responder_if;
  import cpu_pkg::*;

  logic [WORD_W-1:0] fetchAddr;
  logic              fetchEnable;
  logic [WORD_W-1:0] instr;
  logic              instrValid;
  logic              busy;
  logic              fault;
  logic              loadEnable;
  logic [WORD_W-1:0] loadAddr;
  logic [WORD_W-1:0] loadData;

  // Fetch unit / boot loader side.
  modport master (
    output fetchAddr, fetchEnable, loadEnable, loadAddr, loadData,
    input  instr, instrValid, busy, fault
  );

  // Responder side.
  modport slave (
    input  fetchAddr, fetchEnable, loadEnable, loadAddr, loadData,
    output instr, instrValid, busy, fault
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x WORD_W program store: synchronous write, registered read.
// A read and a write to the same word on one edge return the old word.
module imem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register; cleared on reset so the returned word starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, returns the
// addressed word with instrValid after LATENCY cycles, flags bad addresses.
module instr_mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_responder_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  // WAIT ends when the counter reaches this value (unused when LATENCY is 1).
  localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 2);

  // Aligned and below 4*DEPTH bytes.
  function automatic logic addr_ok(input logic [WORD_W-1:0] a);
    return (a[1:0] == 2'b00) && (a[WORD_W-1:AW+2] == '0);
  endfunction

  resp_state_t       state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [WORD_W-1:0] addr_q, addr_n;
  logic [WORD_W-1:0] req_addr;
  logic              enter_resp;
  logic              fault_q;
  logic              rd_en;
  logic              wr_en;
  logic [WORD_W-1:0] rd_data;

  // Next-state logic: accept in IDLE, count in WAIT, one-cycle RESP.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr_q;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fetchEnable) begin
          addr_n = bus.fetchAddr;
          cnt_n  = '0;
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAST_CNT) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // With LATENCY 1 the read happens on the accept edge, before addr_q is loaded.
  always_comb begin
    req_addr = (state == IDLE) ? bus.fetchAddr : addr_q;
  end

  assign rd_en = enter_resp && addr_ok(req_addr);
  assign wr_en = bus.loadEnable && addr_ok(bus.loadAddr);

  // Control state, request address and fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      if (enter_resp) begin
        fault_q <= !addr_ok(req_addr);
      end
    end
  end

  imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (bus.loadAddr[AW+1:2]),
    .wdata (bus.loadData),
    .re    (rd_en),
    .raddr (req_addr[AW+1:2]),
    .rdata (rd_data)
  );

  assign bus.instrValid = (state == RESP);
  assign bus.busy       = (state != IDLE);
  assign bus.fault      = fault_q;
  assign bus.instr      = fault_q ? INSTR_FAULT_WORD : rd_data;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder with a latency-aware scoreboard.
module tb_instr_mem_responder;
  import cpu_pkg::*;

  localparam int DEPTH = 1024;
  localparam int BYTES = 4 * DEPTH;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        q2[$], q4[$], q1[$];
  exp_t        e2, e4, e1;
  logic [31:0] model2 [int];

  instr_mem_responder_if b2 ();
  instr_mem_responder_if b4 ();
  instr_mem_responder_if b1 ();

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  // A fetch driven at the negedge where cyc==c is accepted on edge c+1; the
  // strobe is then seen at the negedge where cyc==c+LATENCY.
  function automatic exp_t expect_resp(input logic [31:0] a, input logic [31:0] word, input int c);
    exp_t e;
    e.cyc = c;
    if (a[1:0] != 2'b00 || a >= 32'(BYTES)) begin
      e.instr = 32'h0;
      e.fault = 1'b1;
    end else begin
      e.instr = word;
      e.fault = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] word2(input logic [31:0] a);
    if (model2.exists(int'(a[11:2]))) return model2[int'(a[11:2])];
    return 32'h0;
  endfunction

  task automatic load2(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    b2.loadEnable = 1'b1;
    b2.loadAddr   = a;
    b2.loadData   = d;
    @(negedge clk);
    b2.loadEnable = 1'b0;
    if (a[1:0] == 2'b00 && a < 32'(BYTES)) model2[int'(a[11:2])] = d;
  endtask

  task automatic issue2(input logic [31:0] a);
    b2.fetchEnable = 1'b1;
    b2.fetchAddr   = a;
    q2.push_back(expect_resp(a, word2(a), cyc + 2));
  endtask

  task automatic wait_idle2();
    int n = 0;
    while (b2.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle2_timeout", {31'd0, b2.busy}, 32'd0);
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (b4.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle4_timeout", {31'd0, b4.busy}, 32'd0);
  endtask

  // Scoreboard monitors: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && b2.instrValid) begin
      if (q2.size() == 0) begin
        check("unexpected_valid2", {31'd0, b2.instrValid}, 32'd0);
      end else begin
        e2 = q2.pop_front();
        check("instr2", b2.instr, e2.instr);
        check("fault2", {31'd0, b2.fault}, {31'd0, e2.fault});
        check("latency2", 32'(cyc), 32'(e2.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b4.instrValid) begin
      if (q4.size() == 0) begin
        check("unexpected_valid4", {31'd0, b4.instrValid}, 32'd0);
      end else begin
        e4 = q4.pop_front();
        check("instr4", b4.instr, e4.instr);
        check("fault4", {31'd0, b4.fault}, {31'd0, e4.fault});
        check("latency4", 32'(cyc), 32'(e4.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b1.instrValid) begin
      if (q1.size() == 0) begin
        check("unexpected_valid1", {31'd0, b1.instrValid}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("instr1", b1.instr, e1.instr);
        check("fault1", {31'd0, b1.fault}, {31'd0, e1.fault});
        check("latency1", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    b2.fetchEnable = 1'b0; b2.fetchAddr = '0; b2.loadEnable = 1'b0; b2.loadAddr = '0; b2.loadData = '0;
    b4.fetchEnable = 1'b0; b4.fetchAddr = '0; b4.loadEnable = 1'b0; b4.loadAddr = '0; b4.loadData = '0;
    b1.fetchEnable = 1'b0; b1.fetchAddr = '0; b1.loadEnable = 1'b0; b1.loadAddr = '0; b1.loadData = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_instr", b2.instr, 32'h0);
    check("rst_valid", {31'd0, b2.instrValid}, 32'd0);
    check("rst_busy", {31'd0, b2.busy}, 32'd0);
    check("rst_fault", {31'd0, b2.fault}, 32'd0);
    check("rst_instr4", b4.instr, 32'h0);
    check("rst_instr1", b1.instr, 32'h0);
    rst = 1'b0;

    // Fill program stores.
    load2(32'h4, 32'h0050_0093);
    load2(32'h0, 32'h1111_1111);
    load2(32'h8, 32'h2222_2222);
    load2(32'hFFC, 32'hCAFE_0FFC);
    @(negedge clk);
    b4.loadEnable = 1'b1; b4.loadAddr = 32'h0; b4.loadData = 32'h0BAD_F00D;
    b1.loadEnable = 1'b1; b1.loadAddr = 32'h0; b1.loadData = 32'hA5A5_0001;
    @(negedge clk);
    b4.loadEnable = 1'b0;
    b1.loadEnable = 1'b0;

    // Single fetch of 0x4 with busy timing around the strobe.
    issue2(32'h4);
    @(negedge clk);
    b2.fetchEnable = 1'b0;
    check("busy_wait", {31'd0, b2.busy}, 32'd1);
    check("valid_early", {31'd0, b2.instrValid}, 32'd0);
    @(negedge clk);
    check("busy_resp", {31'd0, b2.busy}, 32'd1);
    @(negedge clk);
    check("busy_drop", {31'd0, b2.busy}, 32'd0);
    check("valid_one_cycle", {31'd0, b2.instrValid}, 32'd0);
    check("instr_hold", b2.instr, 32'h0050_0093);

    // Back-to-back with fetchEnable held high through busy.
    issue2(32'h0);
    repeat (3) @(negedge clk);
    check("b2b_idle", {31'd0, b2.busy}, 32'd0);
    issue2(32'h8);
    repeat (3) @(negedge clk);
    b2.fetchEnable = 1'b0;
    repeat (4) @(negedge clk);

    // Fault cases and top-of-range word.
    issue2(32'h6);
    @(negedge clk);
    b2.fetchEnable = 1'b0;
    wait_idle2();
    check("instr_hold_fault", b2.instr, 32'h0);
    issue2(32'h1000);
    @(negedge clk);
    b2.fetchEnable = 1'b0;
    wait_idle2();
    issue2(32'hFFC);
    @(negedge clk);
    b2.fetchEnable = 1'b0;
    wait_idle2();

    // Write to word 2 on the same edge that registers its read.
    issue2(32'h8);
    @(negedge clk);
    b2.fetchEnable = 1'b0;
    b2.loadEnable  = 1'b1;
    b2.loadAddr    = 32'h8;
    b2.loadData    = 32'hDEAD_BEEF;
    @(negedge clk);
    b2.loadEnable  = 1'b0;
    model2[2]      = 32'hDEAD_BEEF;
    wait_idle2();
    load2(32'h9, 32'h1234_5678);
    load2(32'h1008, 32'h7777_7777);
    @(negedge clk);
    issue2(32'h8);
    @(negedge clk);
    b2.fetchEnable = 1'b0;
    wait_idle2();

    // Reset one cycle after acceptance on the LATENCY=4 responder.
    b4.fetchEnable = 1'b1;
    b4.fetchAddr   = 32'h0;
    q4.push_back(expect_resp(32'h0, 32'h0BAD_F00D, cyc + 4));
    @(negedge clk);
    b4.fetchEnable = 1'b0;
    rst = 1'b1;
    q4.delete();
    #1;
    check("abort_instr", b4.instr, 32'h0);
    check("abort_valid", {31'd0, b4.instrValid}, 32'd0);
    check("abort_busy", {31'd0, b4.busy}, 32'd0);
    check("abort_fault", {31'd0, b4.fault}, 32'd0);
    check("rst_clears_instr2", b2.instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    b4.fetchEnable = 1'b1;
    b4.fetchAddr   = 32'h0;
    q4.push_back(expect_resp(32'h0, 32'h0BAD_F00D, cyc + 4));
    @(negedge clk);
    b4.fetchEnable = 1'b0;
    wait_idle4();

    // LATENCY=1: strobe on the cycle right after acceptance.
    b1.fetchEnable = 1'b1;
    b1.fetchAddr   = 32'h0;
    q1.push_back(expect_resp(32'h0, 32'hA5A5_0001, cyc + 1));
    @(negedge clk);
    b1.fetchEnable = 1'b0;
    check("lat1_busy_resp", {31'd0, b1.busy}, 32'd1);
    @(negedge clk);
    check("lat1_busy_drop", {31'd0, b1.busy}, 32'd0);
    b1.fetchEnable = 1'b1;
    b1.fetchAddr   = 32'h2;
    q1.push_back(expect_resp(32'h2, 32'h0, cyc + 1));
    @(negedge clk);
    b1.fetchEnable = 1'b0;
    repeat (3) @(negedge clk);

    // Every expected response must have been delivered.
    check("drain2", 32'(q2.size()), 32'd0);
    check("drain4", 32'(q4.size()), 32'd0);
    check("drain1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
